// File: rtl/mcd_pkg.sv
// Shared definitions for the mcd_mem_ctrl bus front-end:
// address windows, register offsets, state and region types.
package mcd_pkg;

    localparam logic [22:0] ROM_BASE  = 23'h400000;
    localparam logic [22:0] ROM_LIMIT = 23'h4FFBFF;
    localparam logic [22:0] SYS_BASE  = 23'h4FFC00;
    localparam logic [22:0] SYS_LIMIT = 23'h4FFFDF;
    localparam logic [22:0] CH2_BASE  = 23'h4FFFE0;
    localparam logic [22:0] CH2_LIMIT = 23'h4FFFEF;
    localparam logic [22:0] CH1_BASE  = 23'h4FFFF0;
    localparam logic [22:0] CH1_LIMIT = 23'h4FFFFF;

    localparam logic [7:0] CH1_STAT_OFF = 8'hF0;
    localparam logic [7:0] CH2_CTRL_OFF = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM,
        ST_REGW,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_ROM,
        REG_SYS,
        REG_CH1,
        REG_CH2,
        REG_NONE
    } region_e;

    // RAM wins if it ever grows over the upper windows.
    function automatic region_e decode_region(input logic [22:0] ba,
                                              input int ram_aw);
        region_e r;
        if ({1'b0, ba} < (24'd1 << (ram_aw + 1)))
            r = REG_RAM;
        else if (ba >= ROM_BASE && ba <= ROM_LIMIT)
            r = REG_ROM;
        else if (ba >= SYS_BASE && ba <= SYS_LIMIT)
            r = REG_SYS;
        else if (ba >= CH2_BASE && ba <= CH2_LIMIT)
            r = REG_CH2;
        else if (ba >= CH1_BASE && ba <= CH1_LIMIT)
            r = REG_CH1;
        else
            r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/mcd_display_timer.sv
// Free-running display period counter producing a registered
// display_active flag for the last ACTIVE_CYCLES of each period.
module mcd_display_timer #(
    parameter int LINE_CYCLES   = 256,
    parameter int ACTIVE_CYCLES = 128
) (
    input  logic clk,
    input  logic reset_n,
    output logic display_active
);

    localparam int CW = $clog2(LINE_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(LINE_CYCLES - 1);
    localparam logic [CW-1:0] START = CW'(LINE_CYCLES - ACTIVE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    // Next counter value and active flag.
    always_comb begin
        cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        active_d = (cnt_q >= START);
    end

    // Timer state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign display_active = active_q;

endmodule

// File: rtl/mcd_mem_ctrl.sv
// 68k-side bus front-end: window decode, boot-ROM overlay,
// external RAM req/ack port and video channel registers.
module mcd_mem_ctrl
    import mcd_pkg::*;
#(
    parameter int RAM_AW        = 21,
    parameter int BOOT_ACCESSES = 4,
    parameter int LINE_CYCLES   = 256,
    parameter int ACTIVE_CYCLES = 128,
    parameter int REG_WAIT      = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [21:0]       address,
    input  logic [15:0]       din,
    output logic [15:0]       dout,
    input  logic              uds,
    input  logic              lds,
    input  logic              write_strobe,
    input  logic              cs,
    output logic              bus_ack,
    output logic              csrom,
    output logic              mem_req,
    output logic              mem_we,
    output logic [RAM_AW-1:0] mem_addr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              display_active
);

    localparam int BW = $clog2(BOOT_ACCESSES + 2);
    localparam logic [BW-1:0] BOOT_MAX = BW'(BOOT_ACCESSES);

    state_e            state_q, state_d;
    logic [15:0]       dout_q, dout_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [RAM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        mem_be_q, mem_be_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]     boot_cnt_q, boot_cnt_d;
    logic [15:0]       ctrl_q, ctrl_d;
    logic [2:0]        wait_q, wait_d;
    region_e           acc_rgn_q, acc_rgn_d;
    logic [7:0]        acc_off_q, acc_off_d;
    logic              acc_we_q, acc_we_d;
    logic [1:0]        acc_be_q, acc_be_d;
    logic [15:0]       acc_wdata_q, acc_wdata_d;

    logic [22:0] byte_addr;
    region_e     region;
    logic        overlay;
    logic        strobe;
    logic [15:0] reg_rdata;

    assign byte_addr = {address, 1'b0};
    assign region    = decode_region(byte_addr, RAM_AW);
    assign overlay   = (boot_cnt_q < BOOT_MAX);
    assign strobe    = uds | lds;
    assign csrom     = cs & ((region == REG_ROM) | overlay);
    assign bus_ack   = (state_q == ST_DONE) |
                       ((state_q == ST_IDLE) & ~cs);

    mcd_display_timer #(
        .LINE_CYCLES  (LINE_CYCLES),
        .ACTIVE_CYCLES(ACTIVE_CYCLES)
    ) u_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .display_active(display_active)
    );

    // Read value of the register captured at cycle start.
    always_comb begin
        reg_rdata = '0;
        if (acc_rgn_q == REG_CH1 && acc_off_q == CH1_STAT_OFF)
            reg_rdata = {8'h0, display_active, 7'h0};
        else if (acc_rgn_q == REG_CH2 && acc_off_q == CH2_CTRL_OFF)
            reg_rdata = ctrl_q;
    end

    // Bus cycle sequencing and register/RAM side effects.
    always_comb begin
        state_d     = state_q;
        dout_d      = dout_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        boot_cnt_d  = boot_cnt_q;
        ctrl_d      = ctrl_q;
        wait_d      = wait_q;
        acc_rgn_d   = acc_rgn_q;
        acc_off_d   = acc_off_q;
        acc_we_d    = acc_we_q;
        acc_be_d    = acc_be_q;
        acc_wdata_d = acc_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cs && strobe) begin
                    if (overlay || region == REG_ROM) begin
                        state_d = ST_DONE;
                    end else if (region == REG_NONE) begin
                        state_d = ST_DONE;
                        if (!write_strobe)
                            dout_d = '0;
                    end else if (region == REG_RAM) begin
                        state_d     = ST_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = write_strobe;
                        mem_addr_d  = address[RAM_AW-1:0];
                        mem_be_d    = {uds, lds};
                        mem_wdata_d = din;
                    end else begin
                        state_d     = ST_REGW;
                        wait_d      = 3'(REG_WAIT);
                        acc_rgn_d   = region;
                        acc_off_d   = byte_addr[7:0];
                        acc_we_d    = write_strobe;
                        acc_be_d    = {uds, lds};
                        acc_wdata_d = din;
                    end
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q)
                        dout_d = mem_rdata;
                end
            end
            ST_REGW: begin
                if (wait_q == 3'd0) begin
                    state_d = ST_DONE;
                    if (!acc_we_q) begin
                        dout_d = reg_rdata;
                    end else if (acc_rgn_q == REG_CH2 &&
                                 acc_off_q == CH2_CTRL_OFF) begin
                        if (acc_be_q[1])
                            ctrl_d[15:8] = acc_wdata_q[15:8];
                        if (acc_be_q[0])
                            ctrl_d[7:0] = acc_wdata_q[7:0];
                    end
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            ST_DONE: begin
                if (!cs || !strobe) begin
                    state_d = ST_IDLE;
                    if (boot_cnt_q != BOOT_MAX)
                        boot_cnt_d = boot_cnt_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dout_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            boot_cnt_q  <= '0;
            ctrl_q      <= '0;
            wait_q      <= '0;
            acc_rgn_q   <= REG_NONE;
            acc_off_q   <= '0;
            acc_we_q    <= 1'b0;
            acc_be_q    <= '0;
            acc_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dout_q      <= dout_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            boot_cnt_q  <= boot_cnt_d;
            ctrl_q      <= ctrl_d;
            wait_q      <= wait_d;
            acc_rgn_q   <= acc_rgn_d;
            acc_off_q   <= acc_off_d;
            acc_we_q    <= acc_we_d;
            acc_be_q    <= acc_be_d;
            acc_wdata_q <= acc_wdata_d;
        end
    end

    assign dout      = dout_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mcd_mem_ctrl.sv
// Randomised self-checking bench for mcd_mem_ctrl with a
// behavioural RAM/register/timer model and an SDRAM responder.
module tb_mcd_mem_ctrl;

    localparam int RAM_AW = 21;
    localparam int BOOT   = 4;
    localparam int LINE   = 256;
    localparam int ACTIVE = 128;
    localparam int RWAIT  = 1;

    logic              clk, reset_n;
    logic [21:0]       address;
    logic [15:0]       din, dout;
    logic              uds, lds, write_strobe, cs;
    logic              bus_ack, csrom;
    logic              mem_req, mem_we;
    logic [RAM_AW-1:0] mem_addr;
    logic [1:0]        mem_be;
    logic [15:0]       mem_wdata, mem_rdata;
    logic              mem_ack, display_active;

    int checks = 0;
    int errors = 0;

    mcd_mem_ctrl #(
        .RAM_AW(RAM_AW), .BOOT_ACCESSES(BOOT), .LINE_CYCLES(LINE),
        .ACTIVE_CYCLES(ACTIVE), .REG_WAIT(RWAIT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .din(din),
        .dout(dout), .uds(uds), .lds(lds), .write_strobe(write_strobe),
        .cs(cs), .bus_ack(bus_ack), .csrom(csrom), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .display_active(display_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Display model: clock edges since reset release.
    int tcnt;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) tcnt <= 0;
        else tcnt <= tcnt + 1;

    function automatic bit exp_active();
        return (tcnt > 0) && (((tcnt - 1) % LINE) >= (LINE - ACTIVE));
    endfunction

    // External RAM contents model.
    logic [15:0] ram_m [int];
    function automatic logic [15:0] ram_rd(input int a);
        if (ram_m.exists(a)) return ram_m[a];
        return 16'(a * 7) ^ 16'hC3A5;
    endfunction

    // Responder controls (main) and captures (responder).
    int          resp_lat = 0;
    bit          resp_en = 1;
    bit          rd_ovr_en = 0;
    logic [15:0] rd_ovr_val = '0;
    int          pulse_cnt = 0;
    int          pulse_done = 0;
    logic [20:0] cap_addr;
    logic [1:0]  cap_be;
    logic        cap_we;
    logic [15:0] cap_wdata;

    always begin
        @(posedge clk); #1;
        if (pulse_cnt != pulse_done) begin
            pulse_done = pulse_cnt;
            mem_rdata = 16'hDEAD;
            mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end else if (resp_en && mem_req) begin
            for (int i = 0; i < resp_lat; i++) begin
                @(posedge clk); #1;
            end
            cap_addr  = mem_addr;
            cap_be    = mem_be;
            cap_we    = mem_we;
            cap_wdata = mem_wdata;
            mem_rdata = rd_ovr_en ? rd_ovr_val : ram_rd(int'(mem_addr));
            mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
    end

    logic [15:0] exp_dout = '0;
    logic [15:0] ctrl_m = '0;
    int          boot_n = 0;

    task automatic bus_cycle(input logic [22:0] ba, input bit we,
                             input bit u, input bit l,
                             input logic [15:0] wd,
                             output logic [15:0] rd, output int edges,
                             output bit saw_rom, output bit saw_req);
        @(posedge clk); #1;
        address = ba[22:1];
        din = wd;
        write_strobe = we;
        uds = u;
        lds = l;
        cs = 1'b1;
        edges = 0;
        saw_req = 1'b0;
        #1 saw_rom = csrom;
        do begin
            @(posedge clk); #1;
            edges++;
            if (csrom) saw_rom = 1'b1;
            if (mem_req) saw_req = 1'b1;
        end while (!bus_ack && edges < 200);
        rd = dout;
        cs = 1'b0;
        uds = 1'b0;
        lds = 1'b0;
        @(posedge clk); #1;
        boot_n++;
    endtask

    task automatic test_reset();
        checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0000", dout); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_be !== 2'b00 || mem_addr !== '0) begin errors++; $display("FAIL reset_mem_port: got be=%b addr=%h expected 0", mem_be, mem_addr); end
        checks++; if (bus_ack !== 1'b1) begin errors++; $display("FAIL reset_bus_ack: got %b expected 1", bus_ack); end
        checks++; if (display_active !== 1'b0) begin errors++; $display("FAIL reset_display: got %b expected 0", display_active); end
    endtask

    task automatic test_boot_overlay();
        logic [15:0] rd;
        int e;
        bit sr, sq;
        resp_lat = 1;
        for (int i = 0; i < BOOT; i++) begin
            bus_cycle(23'h000000, 0, 1, 1, 16'h0, rd, e, sr, sq);
            checks++; if (sr !== 1'b1) begin errors++; $display("FAIL boot_csrom%0d: got %b expected 1", i, sr); end
            checks++; if (sq !== 1'b0) begin errors++; $display("FAIL boot_no_req%0d: got %b expected 0", i, sq); end
            checks++; if (e != 1) begin errors++; $display("FAIL boot_lat%0d: got %0d expected 1", i, e); end
            checks++; if (rd !== exp_dout) begin errors++; $display("FAIL boot_dout%0d: got %h expected %h", i, rd, exp_dout); end
        end
        bus_cycle(23'h000000, 0, 1, 1, 16'h0, rd, e, sr, sq);
        exp_dout = ram_rd(0);
        checks++; if (sq !== 1'b1 || sr !== 1'b0) begin errors++; $display("FAIL boot_expired: got req=%b rom=%b expected req=1 rom=0", sq, sr); end
        checks++; if (cap_addr !== 21'h0) begin errors++; $display("FAIL boot_ram_addr: got %h expected 0", cap_addr); end
        checks++; if (rd !== exp_dout) begin errors++; $display("FAIL boot_ram_dout: got %h expected %h", rd, exp_dout); end
    endtask

    task automatic test_ram_write();
        logic [15:0] rd;
        int e;
        bit sr, sq;
        resp_lat = 3;
        bus_cycle(23'h001000, 1, 1, 1, 16'h5AA5, rd, e, sr, sq);
        ram_m[32'h800] = 16'h5AA5;
        checks++; if (cap_be !== 2'b11 || cap_we !== 1'b1) begin errors++; $display("FAIL wr_word_be: got be=%b we=%b expected be=11 we=1", cap_be, cap_we); end
        checks++; if (cap_addr !== 21'h800) begin errors++; $display("FAIL wr_word_addr: got %h expected 800", cap_addr); end
        checks++; if (cap_wdata !== 16'h5AA5) begin errors++; $display("FAIL wr_word_data: got %h expected 5aa5", cap_wdata); end
        checks++; if (e != resp_lat + 2) begin errors++; $display("FAIL wr_word_lat: got %0d expected %0d", e, resp_lat + 2); end
        bus_cycle(23'h001000, 1, 0, 1, 16'h0033, rd, e, sr, sq);
        ram_m[32'h800] = 16'h5A33;
        checks++; if (cap_be !== 2'b01) begin errors++; $display("FAIL wr_lds_be: got %b expected 01", cap_be); end
        checks++; if (e != resp_lat + 2) begin errors++; $display("FAIL wr_lds_lat: got %0d expected %0d", e, resp_lat + 2); end
        checks++; if (rd !== exp_dout) begin errors++; $display("FAIL wr_dout_held: got %h expected %h", rd, exp_dout); end
    endtask

    task automatic test_ram_read_latency();
        logic [15:0] rd;
        int e;
        bit sr, sq;
        resp_lat = 5;
        rd_ovr_en = 1;
        rd_ovr_val = 16'h1234;
        bus_cycle(23'h001000, 0, 1, 1, 16'h0, rd, e, sr, sq);
        rd_ovr_en = 0;
        exp_dout = 16'h1234;
        checks++; if (e != 7) begin errors++; $display("FAIL rd_slow_lat: got %0d expected 7", e); end
        checks++; if (rd !== exp_dout) begin errors++; $display("FAIL rd_slow_dout: got %h expected %h", rd, exp_dout); end
        resp_lat = 0;
        bus_cycle(23'h001000, 0, 1, 1, 16'h0, rd, e, sr, sq);
        exp_dout = 16'h5A33;
        checks++; if (rd !== exp_dout) begin errors++; $display("FAIL rd_back_dout: got %h expected %h", rd, exp_dout); end
        checks++; if (e != 2) begin errors++; $display("FAIL rd_fast_lat: got %0d expected 2", e); end
    endtask

    task automatic test_ch1_status();
        logic [15:0] rd;
        int e;
        bit sr, sq;
        for (int i = 0; i < 3 * LINE && (tcnt % LINE) != LINE - ACTIVE + 20; i++) begin
            @(posedge clk); #1;
        end
        checks++; if (display_active !== exp_active()) begin errors++; $display("FAIL ch1_timer_on: got %b expected %b", display_active, exp_active()); end
        bus_cycle(23'h4FFFF0, 0, 1, 1, 16'h0, rd, e, sr, sq);
        checks++; if (rd !== 16'h0080) begin errors++; $display("FAIL ch1_active: got %h expected 0080", rd); end
        checks++; if (e != RWAIT + 2) begin errors++; $display("FAIL ch1_lat: got %0d expected %0d", e, RWAIT + 2); end
        for (int i = 0; i < 3 * LINE && (tcnt % LINE) != 5; i++) begin
            @(posedge clk); #1;
        end
        checks++; if (display_active !== exp_active()) begin errors++; $display("FAIL ch1_timer_off: got %b expected %b", display_active, exp_active()); end
        bus_cycle(23'h4FFFF0, 0, 1, 1, 16'h0, rd, e, sr, sq);
        exp_dout = 16'h0000;
        checks++; if (rd !== exp_dout) begin errors++; $display("FAIL ch1_idle: got %h expected 0000", rd); end
    endtask

    task automatic test_ch2_ctrl();
        logic [15:0] rd;
        int e;
        bit sr, sq;
        bus_cycle(23'h4FFFE0, 1, 1, 0, 16'hBEEF, rd, e, sr, sq);
        ctrl_m[15:8] = 8'hBE;
        checks++; if (e != RWAIT + 2) begin errors++; $display("FAIL ch2_wr_lat: got %0d expected %0d", e, RWAIT + 2); end
        bus_cycle(23'h4FFFE0, 0, 1, 1, 16'h0, rd, e, sr, sq);
        exp_dout = ctrl_m;
        checks++; if (rd !== 16'hBE00) begin errors++; $display("FAIL ch2_readback: got %h expected be00", rd); end
    endtask

    task automatic test_random();
        logic [15:0] rd, wd, old;
        logic [22:0] ba;
        int e, kind, w, lat;
        bit sr, sq, we, u, l, off0;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 5);
            we = 1'($urandom_range(0, 1));
            w = $urandom_range(1, 3);
            u = w[1];
            l = w[0];
            wd = 16'($urandom);
            lat = $urandom_range(0, 4);
            resp_lat = lat;
            off0 = 1'b0;
            w = 32'h800 + $urandom_range(0, 31);
            case (kind)
                0: ba = 23'(w) << 1;
                1: ba = 23'h400000 + (23'($urandom_range(0, 16'hFFFF)) << 1);
                2: ba = 23'h4FFC00 + (23'($urandom_range(0, 16'h1EF)) << 1);
                3: ba = 23'h4FFFF0 + (23'($urandom_range(1, 7)) << 1);
                4: begin
                    off0 = 1'($urandom_range(0, 1));
                    ba = off0 ? 23'h4FFFE0 : 23'h4FFFE0 + (23'($urandom_range(1, 7)) << 1);
                end
                default: ba = 23'h500000 + (23'($urandom_range(0, 20'hFFFFF)) << 1);
            endcase
            bus_cycle(ba, we, u, l, wd, rd, e, sr, sq);
            if (kind == 0) begin
                old = ram_rd(w);
                if (we) ram_m[w] = {u ? wd[15:8] : old[15:8], l ? wd[7:0] : old[7:0]};
                else exp_dout = old;
                checks++; if (cap_addr !== 21'(w) || cap_be !== {u, l} || cap_we !== we) begin errors++; $display("FAIL rnd%0d_ram_port: got a=%h be=%b we=%b expected a=%h be=%b we=%b", it, cap_addr, cap_be, cap_we, w, {u, l}, we); end
                checks++; if (we && cap_wdata !== wd) begin errors++; $display("FAIL rnd%0d_ram_wdata: got %h expected %h", it, cap_wdata, wd); end
                checks++; if (e != lat + 2) begin errors++; $display("FAIL rnd%0d_ram_lat: got %0d expected %0d", it, e, lat + 2); end
            end else if (kind == 1 || kind == 5) begin
                if (kind == 5 && !we) exp_dout = 16'h0;
                checks++; if (e != 1) begin errors++; $display("FAIL rnd%0d_fast_lat: got %0d expected 1", it, e); end
            end else begin
                if (kind == 4 && off0 && we) begin
                    if (u) ctrl_m[15:8] = wd[15:8];
                    if (l) ctrl_m[7:0] = wd[7:0];
                end
                if (!we) exp_dout = (kind == 4 && off0) ? ctrl_m : 16'h0;
                checks++; if (e != RWAIT + 2) begin errors++; $display("FAIL rnd%0d_reg_lat: got %0d expected %0d", it, e, RWAIT + 2); end
            end
            checks++; if (rd !== exp_dout) begin errors++; $display("FAIL rnd%0d_dout: kind %0d got %h expected %h", it, kind, rd, exp_dout); end
            checks++; if (sq !== (kind == 0) || sr !== (kind == 1)) begin errors++; $display("FAIL rnd%0d_select: kind %0d got req=%b rom=%b", it, kind, sq, sr); end
            checks++; if (display_active !== exp_active()) begin errors++; $display("FAIL rnd%0d_timer: got %b expected %b", it, display_active, exp_active()); end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [15:0] rd;
        int e;
        bit sr, sq;
        resp_en = 0;
        @(posedge clk); #1;
        address = 22'h000800;
        write_strobe = 1'b0;
        uds = 1'b1;
        lds = 1'b1;
        cs = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mem_req_on: got %b expected 1", mem_req); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req_drop: got %b expected 0", mem_req); end
        cs = 1'b0;
        uds = 1'b0;
        lds = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        boot_n = 0;
        exp_dout = 16'h0;
        pulse_cnt++;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_ack !== 1'b1 || dout !== 16'h0 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_stray_ack: got ack=%b dout=%h req=%b expected 1 0000 0", bus_ack, dout, mem_req); end
        cs = 1'b1;
        #1;
        checks++; if (bus_ack !== 1'b0) begin errors++; $display("FAIL rst_idle_state: got %b expected 0", bus_ack); end
        cs = 1'b0;
        resp_en = 1;
        bus_cycle(23'h000000, 0, 1, 1, 16'h0, rd, e, sr, sq);
        checks++; if (sr !== 1'b1 || sq !== 1'b0 || rd !== exp_dout) begin errors++; $display("FAIL rst_overlay: got rom=%b req=%b dout=%h expected 1 0 0000", sr, sq, rd); end
        checks++; if (display_active !== exp_active()) begin errors++; $display("FAIL rst_timer: got %b expected %b", display_active, exp_active()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        address = '0;
        din = '0;
        uds = 1'b0;
        lds = 1'b0;
        write_strobe = 1'b0;
        cs = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        test_reset();
        test_boot_overlay();
        test_ram_write();
        test_ram_read_latency();
        test_ch1_status();
        test_ch2_ctrl();
        test_random();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
